// File: rtl/axi4_rd_reorder_buf.sv
// Read reorder buffer: forwards ARs, buffers R beats per outstanding AR and replays them in
// AR-issue order. Optional macro RD_REORDER_RRESP_EN stores and replays rresp per beat.
module axi4_rd_reorder_buf #(
  parameter int unsigned IDSIZE = 8,
  parameter int unsigned ASIZE  = 32,
  parameter int unsigned LSIZE  = 8,
  parameter int unsigned DSIZE  = 32,
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned MAXLEN = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  // AR from upstream
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [IDSIZE-1:0] s_arid,
  input  logic [ASIZE-1:0]  s_araddr,
  input  logic [LSIZE-1:0]  s_arlen,
  // AR to memory
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [IDSIZE-1:0] m_arid,
  output logic [ASIZE-1:0]  m_araddr,
  output logic [LSIZE-1:0]  m_arlen,
  // R from memory
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [IDSIZE-1:0] m_rid,
  input  logic [DSIZE-1:0]  m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  // In-order R to upstream
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [IDSIZE-1:0] s_rid,
  output logic [DSIZE-1:0]  s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  // Sticky error flags
  output logic              err_len,
  output logic              err_id
);

  localparam int unsigned BW = $clog2(MAXLEN + 1);
  localparam int unsigned PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned UW = $clog2(SLOTS + 1);
  localparam int unsigned IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int unsigned CW = (BW > LSIZE) ? BW : LSIZE;

  // Slot table
  logic [SLOTS-1:0]  slot_vld_q;
  logic [SLOTS-1:0]  slot_cls_q;
  logic [IDSIZE-1:0] slot_id_q    [SLOTS];
  logic [LSIZE-1:0]  slot_len_q   [SLOTS];
  logic [BW-1:0]     slot_beats_q [SLOTS];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [UW-1:0] used_q;
  logic [BW-1:0] rcnt_q;

  logic [DSIZE-1:0] mem_data [SLOTS][MAXLEN];

  logic          ar_hs;
  logic          alloc;
  logic          rd_hs;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] scan_idx;
  logic [BW-1:0] hit_beats;
  logic [LSIZE-1:0] hit_len;
  logic          beat_store;
  logic          beat_over;
  logic          beat_close;
  logic          head_avail;
  logic          head_last;
  logic [BW-1:0] head_beats;
  logic          s_pop;
  logic          retire;
  logic          out_free;
  logic          load;
  logic          err_len_d;
  logic          err_id_d;

  // AR path
  always_comb begin
    s_arready = (used_q < UW'(SLOTS)) && (!m_arvalid || m_arready);
    ar_hs     = s_arvalid && s_arready;
    alloc     = ar_hs;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
    end else if (ar_hs) begin
      m_arvalid <= 1'b1;
      m_arid    <= s_arid;
      m_araddr  <= s_araddr;
      m_arlen   <= s_arlen;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  // Storage is pre-allocated per slot, so R is always accepted once out of reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) m_rready <= 1'b0;
    else        m_rready <= 1'b1;
  end

  // Oldest open slot with a matching id, scanning from the head.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = rd_ptr_q;
    scan_idx = rd_ptr_q;
    for (int i = 0; i < SLOTS; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (!hit && slot_vld_q[scan_idx] && !slot_cls_q[scan_idx] &&
          (slot_id_q[scan_idx] == m_rid)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  always_comb begin
    rd_hs      = m_rvalid && m_rready;
    hit_beats  = slot_beats_q[hit_idx];
    hit_len    = slot_len_q[hit_idx];
    beat_store = rd_hs && hit && (hit_beats < BW'(MAXLEN));
    beat_over  = rd_hs && hit && !beat_store;
    beat_close = rd_hs && hit && (m_rlast || (CW'(hit_beats) == CW'(hit_len)));
  end

  // Output stage: stream beat rcnt of the head slot once it has been stored.
  always_comb begin
    head_beats = slot_beats_q[rd_ptr_q];
    head_avail = slot_vld_q[rd_ptr_q] && (head_beats > rcnt_q);
    head_last  = (CW'(rcnt_q) == CW'(slot_len_q[rd_ptr_q])) ||
                 (slot_cls_q[rd_ptr_q] && (head_beats == rcnt_q + BW'(1)));
    s_pop      = s_rvalid && s_rready;
    retire     = s_pop && s_rlast;
    // A pending last beat blocks further loads until its slot retires.
    out_free   = !s_rvalid || (s_pop && !s_rlast);
    load       = out_free && head_avail;
  end

  always_comb begin
    err_id_d  = err_id || (rd_hs && !hit);
    err_len_d = err_len || beat_over || (ar_hs && (CW'(s_arlen) >= CW'(MAXLEN)));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_len <= 1'b0;
      err_id  <= 1'b0;
    end else begin
      err_len <= err_len_d;
      err_id  <= err_id_d;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      slot_cls_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_id_q[i]    <= '0;
        slot_len_q[i]   <= '0;
        slot_beats_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        slot_vld_q[wr_ptr_q]   <= 1'b1;
        slot_cls_q[wr_ptr_q]   <= 1'b0;
        slot_id_q[wr_ptr_q]    <= s_arid;
        slot_len_q[wr_ptr_q]   <= s_arlen;
        slot_beats_q[wr_ptr_q] <= '0;
      end
      if (beat_store) slot_beats_q[hit_idx] <= hit_beats + BW'(1);
      if (beat_close) slot_cls_q[hit_idx] <= 1'b1;
      if (retire)     slot_vld_q[rd_ptr_q] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      if (alloc)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (retire) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({alloc, retire})
        2'b10:   used_q <= used_q + UW'(1);
        2'b01:   used_q <= used_q - UW'(1);
        default: used_q <= used_q;
      endcase
      if (retire)    rcnt_q <= '0;
      else if (load) rcnt_q <= rcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (beat_store) mem_data[hit_idx][hit_beats[IW-1:0]] <= m_rdata;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rid    <= '0;
      s_rdata  <= '0;
      s_rlast  <= 1'b0;
    end else if (load) begin
      s_rvalid <= 1'b1;
      s_rid    <= slot_id_q[rd_ptr_q];
      s_rdata  <= mem_data[rd_ptr_q][rcnt_q[IW-1:0]];
      s_rlast  <= head_last;
    end else if (s_pop) begin
      s_rvalid <= 1'b0;
    end
  end

`ifdef RD_REORDER_RRESP_EN
  logic [1:0] mem_resp [SLOTS][MAXLEN];

  always_ff @(posedge clock) begin
    if (beat_store) mem_resp[hit_idx][hit_beats[IW-1:0]] <= m_rresp;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)    s_rresp <= 2'b00;
    else if (load) s_rresp <= mem_resp[rd_ptr_q][rcnt_q[IW-1:0]];
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^m_rresp;
  assign s_rresp      = 2'b00;
`endif

endmodule

// File: tb/tb_axi4_rd_reorder_buf.sv
// Bench for axi4_rd_reorder_buf: random R return order checked against an AR-issue-order
// model of the replayed stream, plus full-ring, backpressure, error and reset scenarios.
module tb_axi4_rd_reorder_buf;
  localparam int unsigned IDSIZE = 8;
  localparam int unsigned ASIZE  = 32;
  localparam int unsigned LSIZE  = 8;
  localparam int unsigned DSIZE  = 32;
  localparam int unsigned SLOTS  = 4;
  localparam int unsigned MAXLEN = 16;

  typedef logic [IDSIZE+DSIZE+2:0]       beat_t;  // {id, data, resp, last}
  typedef logic [IDSIZE+ASIZE+LSIZE-1:0] ar_t;    // {id, addr, len}

  logic clock = 1'b0;
  logic rst_n;
  logic s_arvalid, s_arready;
  logic [IDSIZE-1:0] s_arid, m_arid, m_rid, s_rid;
  logic [ASIZE-1:0]  s_araddr, m_araddr;
  logic [LSIZE-1:0]  s_arlen, m_arlen;
  logic m_arvalid, m_arready;
  logic m_rvalid, m_rready, m_rlast;
  logic [DSIZE-1:0] m_rdata, s_rdata;
  logic [1:0] m_rresp, s_rresp;
  logic s_rvalid, s_rready, s_rlast;
  logic err_len, err_id;

  axi4_rd_reorder_buf #(
    .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .SLOTS(SLOTS), .MAXLEN(MAXLEN)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err_len(err_len), .err_id(err_id)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  beat_t got[$];
  beat_t exp[$];
  ar_t   ar_got[$];
  ar_t   ar_exp[$];
  int    rr_mode = 1;  // s_rready: 0 low, 1 high, 2 random
  int    ma_mode = 1;  // m_arready: same encoding
  logic [31:0] last_addr;

  logic [7:0]  ar_id  [8];
  int          ar_len [8];
  logic [31:0] dat    [8][MAXLEN];
  logic [1:0]  rsp    [8][MAXLEN];

  always @(posedge clock) begin
    #1;
    s_rready  = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
    m_arready = (ma_mode == 2) ? 1'($urandom_range(0, 1)) : (ma_mode == 1);
  end

  always @(negedge clock) begin
    if (rst_n && s_rvalid && s_rready) got.push_back({s_rid, s_rdata, s_rresp, s_rlast});
    if (rst_n && m_arvalid && m_arready) ar_got.push_back({m_arid, m_araddr, m_arlen});
  end

  function automatic logic [1:0] exp_resp(input logic [1:0] r);
`ifdef RD_REORDER_RRESP_EN
    return r;
`else
    return 2'b00;
`endif
  endfunction

  task automatic set_ar(input int k, input logic [7:0] id, input int len);
    ar_id[k]  = id;
    ar_len[k] = len;
    for (int b = 0; b < MAXLEN; b++) begin
      dat[k][b] = $urandom;
      rsp[k][b] = 2'($urandom_range(0, 3));
    end
  endtask

  // Replay order is AR-issue order, each burst complete, whatever the return order was.
  task automatic push_exp(input int k);
    for (int b = 0; b <= ar_len[k]; b++)
      exp.push_back({ar_id[k], dat[k][b], exp_resp(rsp[k][b]), 1'(b == ar_len[k])});
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [7:0] len);
    bit ok = 0;
    @(posedge clock);
    #1;
    last_addr = $urandom;
    s_arvalid = 1'b1; s_arid = id; s_araddr = last_addr; s_arlen = len;
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      if (s_arready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_accept_timeout id %h got no s_arready, wanted s_arready=1", id);
    end
    @(posedge clock);
    #1;
    s_arvalid = 1'b0;
    ar_exp.push_back({id, last_addr, len});
  endtask

  task automatic send_r(input logic [7:0] id, input logic [31:0] d, input logic [1:0] r,
                        input logic last);
    bit ok = 0;
    @(posedge clock);
    #1;
    m_rvalid = 1'b1; m_rid = id; m_rdata = d; m_rresp = r; m_rlast = last;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (m_rready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL r_accept_timeout id %h got m_rready=0, wanted 1", id);
    end
    @(posedge clock);
    #1;
    m_rvalid = 1'b0;
  endtask

  // mode 0: return bursts in issue order, 1: reverse order, 2: random same-id-legal interleave.
  task automatic drive_traffic(input int n, input int mode);
    int nxt[8];
    int elig[8];
    int ne;
    int k;
    for (int i = 0; i < n; i++) begin
      send_ar(ar_id[i], 8'(ar_len[i]));
      push_exp(i);
      nxt[i] = 0;
    end
    for (int it = 0; it < 8 * MAXLEN; it++) begin
      ne = 0;
      for (int i = 0; i < n; i++) begin
        bit older = 0;
        for (int j = 0; j < i; j++)
          if (ar_id[j] == ar_id[i] && nxt[j] <= ar_len[j]) older = 1;
        if (nxt[i] <= ar_len[i] && !older) begin elig[ne] = i; ne++; end
      end
      if (ne == 0) break;
      if (mode == 0)      k = elig[0];
      else if (mode == 1) k = elig[ne-1];
      else                k = elig[$urandom_range(0, ne - 1)];
      send_r(ar_id[k], dat[k][nxt[k]], rsp[k][nxt[k]], 1'(nxt[k] == ar_len[k]));
      nxt[k]++;
      if (mode == 2) repeat ($urandom_range(0, 2)) @(posedge clock);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && got.size() < exp.size(); c++) @(negedge clock);
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    s_rready = 1'b1; m_arready = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid got %b want 0", m_arvalid); end
    checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL rst_s_rvalid got %b want 0", s_rvalid); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rst_m_rready got %b want 0", m_rready); end
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL rst_s_arready got %b want 1", s_arready); end
    checks++; if ({err_len, err_id} !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", {err_len, err_id}); end
    rst_n = 1'b1;
    #1;
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rel_m_rready got %b want 0", m_rready); end
    @(negedge clock);
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL post_rel_m_rready got %b want 1", m_rready); end
  endtask

  task automatic test_in_order();
    set_ar(0, 8'h10, 3);
    send_ar(8'h10, 8'd3);
    push_exp(0);
    checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL ar_fwd_valid got %b want 1", m_arvalid); end
    checks++;
    if ({m_arid, m_araddr, m_arlen} !== {8'h10, last_addr, 8'd3}) begin
      errors++; $display("FAIL ar_fwd_payload got %h want %h", {m_arid, m_araddr, m_arlen}, {8'h10, last_addr, 8'd3});
    end
    for (int b = 0; b <= 3; b++) send_r(8'h10, dat[0][b], rsp[0][b], 1'(b == 3));
    wait_drain();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL inorder_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL inorder_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if ({err_len, err_id} !== 2'b00) begin errors++; $display("FAIL inorder_err got %b want 00", {err_len, err_id}); end
    got.delete(); exp.delete();
  endtask

  task automatic test_swap();
    set_ar(0, 8'h11, 1);
    set_ar(1, 8'h12, 1);
    drive_traffic(2, 1);
    wait_drain();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL swap_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL swap_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    got.delete(); exp.delete();
  endtask

  task automatic test_full();
    bit stalled = 1;
    bit seen = 0;
    for (int k = 0; k < 4; k++) begin
      set_ar(k, 8'(8'h20 + k), 0);
      send_ar(ar_id[k], 8'd0);
      push_exp(k);
    end
    set_ar(4, 8'h24, 0);
    @(posedge clock);
    #1;
    s_arvalid = 1'b1; s_arid = 8'h24; s_araddr = $urandom; s_arlen = 8'd0;
    repeat (3) begin
      @(negedge clock);
      if (s_arready !== 1'b0) stalled = 0;
    end
    checks++; if (!stalled) begin errors++; $display("FAIL full_stall got s_arready=1 want 0"); end
    send_r(8'h20, dat[0][0], rsp[0][0], 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (s_rvalid && s_rready && s_rlast) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL full_head_last got no s_rlast handshake want one"); end
    checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL full_ready_at_last got %b want 0", s_arready); end
    @(negedge clock);
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL full_ready_after_last got %b want 1", s_arready); end
    @(posedge clock);
    #1;
    s_arvalid = 1'b0;
    push_exp(4);
    for (int k = 4; k >= 1; k--) send_r(ar_id[k], dat[k][0], rsp[k][0], 1'b1);
    wait_drain();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL full_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL full_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    got.delete(); exp.delete();
  endtask

  task automatic test_backpressure();
    bit rready_ok = 1;
    rr_mode = 0;
    set_ar(0, 8'h60, 7);
    set_ar(1, 8'h61, 3);
    drive_traffic(2, 2);
    repeat (20) begin
      @(negedge clock);
      if (m_rready !== 1'b1) rready_ok = 0;
    end
    checks++; if (!rready_ok) begin errors++; $display("FAIL bp_m_rready got 0 want 1 throughout"); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL bp_held got %0d beats want 0", got.size()); end
    checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL bp_s_rvalid got %b want 1", s_rvalid); end
    rr_mode = 2;
    wait_drain();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    got.delete(); exp.delete();
    rr_mode = 1;
  endtask

  task automatic test_random();
    int n;
    repeat (3) @(negedge clock);
    ar_got.delete(); ar_exp.delete();
    rr_mode = 2; ma_mode = 2;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) set_ar(k, 8'(8'h40 + $urandom_range(0, 2)), $urandom_range(0, MAXLEN - 1));
      drive_traffic(n, 2);
      wait_drain();
      checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_beat%0d got %h want %h", r, i, got[i], exp[i]); end
      end
      got.delete(); exp.delete();
    end
    checks++; if (ar_got.size() !== ar_exp.size()) begin errors++; $display("FAIL rand_ar_count got %0d want %0d", ar_got.size(), ar_exp.size()); end
    for (int i = 0; i < ar_exp.size() && i < ar_got.size(); i++) begin
      checks++; if (ar_got[i] !== ar_exp[i]) begin errors++; $display("FAIL rand_ar%0d got %h want %h", i, ar_got[i], ar_exp[i]); end
    end
    rr_mode = 1; ma_mode = 1;
  endtask

  task automatic test_errors();
    send_r(8'h7F, 32'hDEAD_BEEF, 2'b00, 1'b1);
    @(negedge clock);
    checks++; if (err_id !== 1'b1) begin errors++; $display("FAIL err_id_set got %b want 1", err_id); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL err_len_clear got %b want 0", err_len); end
    send_ar(8'h50, 8'(MAXLEN));
    @(negedge clock);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL err_len_set got %b want 1", err_len); end
    repeat (10) @(negedge clock);
    checks++; if ({err_len, err_id} !== 2'b11) begin errors++; $display("FAIL err_sticky got %b want 11", {err_len, err_id}); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL err_dropped got %0d beats want 0", got.size()); end
  endtask

  task automatic test_reset_mid();
    set_ar(0, 8'h30, 3);
    send_ar(8'h30, 8'd3);
    send_r(8'h30, dat[0][0], rsp[0][0], 1'b0);
    send_r(8'h30, dat[0][1], rsp[0][1], 1'b0);
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({m_arvalid, s_rvalid, m_rready} !== 3'b000) begin errors++; $display("FAIL mid_rst_valids got %b want 000", {m_arvalid, s_rvalid, m_rready}); end
    checks++; if ({err_len, err_id} !== 2'b00) begin errors++; $display("FAIL mid_rst_err got %b want 00", {err_len, err_id}); end
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL mid_rst_arready got %b want 1", s_arready); end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    got.delete(); exp.delete();
    send_r(8'h30, dat[0][2], rsp[0][2], 1'b0);
    repeat (4) @(negedge clock);
    checks++; if (err_id !== 1'b1) begin errors++; $display("FAIL late_r_err_id got %b want 1", err_id); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL late_r_dropped got %0d beats want 0", got.size()); end
    set_ar(0, 8'h31, 2);
    drive_traffic(1, 0);
    wait_drain();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL post_rst_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL post_rst_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_swap();
    test_full();
    test_backpressure();
    test_random();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
